sha256_main_round: RTL and testbench
====================================

Name: sha256_main_round

Overview:
- Compression stage directly downstream of the W-schedule calculator.
- Consumes one schedule word Wt per w_vld beat, indexed by w_cnt 0..63.
- Runs the 64 SHA-256 rounds on working registers a..h, then folds the result into the chained hash H0..H7.
- Presents the 256-bit digest with a one-cycle done pulse per 512-bit block; supports multi-block messages via msg_init.

Parameters:
- P_ROUNDS, 64, rounds per block; fixed by the algorithm and only used for the last-beat compare.

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- msg_init  input  1  pulse: reload H0..H7 with the IV before the first block of a new message
- w_vld  input  1  Wt/w_cnt valid this cycle; same timing as the schedule block's enable
- w_cnt  input  6  round index of the current beat
- Wt  input  32  schedule word for round w_cnt
- busy  output  1  high from the w_cnt==0 beat until the H update cycle completes
- blk_done  output  1  one-cycle pulse when H0..H7 are updated for a block
- seq_err  output  1  sticky error flag for an out-of-sequence beat; cleared by msg_init or reset
- digest  output  256  {H0,...,H7}; H0 occupies bits [255:224]

Behaviour:
- Reset (asynchronous, active-low):
  - H0..H7 = IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - a..h = 0, round counter = 0, state = IDLE.
  - busy = 0, blk_done = 0, seq_err = 0; digest therefore = IV.
- State machine:
  - IDLE:
    - Beat with w_cnt==0: round 0 is computed using H0..H7 as the a..h source (mux); results go into a..h; counter = 1; go to ROUND.
    - Beat with w_cnt!=0: ignored; seq_err set.
  - ROUND:
    - Beat with w_cnt == counter: one round is computed from a..h, K[w_cnt] and Wt; counter increments.
    - Beat with w_cnt != counter: ignored; seq_err set; no state change.
    - Beat with w_cnt==63: go to UPDATE.
    - No beat: hold all state; stalls of any length are legal.
  - UPDATE (one cycle):
    - Hi <= Hi + {a..h}i, mod 2^32.
    - blk_done = 1 this cycle, registered output.
    - Go to IDLE.
    - Any w_vld during UPDATE is ignored and sets seq_err.
- Round arithmetic, all mod 2^32:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt
  - T2 = Σ0(a) + Maj(a,b,c)
  - a' = T1+T2, e' = d+T1; b'=a, c'=b, d'=c, f'=e, g'=f, h'=g
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c)
- Latency:
  - One round per w_vld beat.
  - digest is valid in the cycle after blk_done (registered H); blk_done rises the cycle after the w_cnt==63 beat.
- msg_init:
  - In IDLE: reloads IV and clears seq_err next cycle.
  - In ROUND/UPDATE: aborts the block, returns to IDLE, clears a..h and the counter; the H update is skipped.
  - msg_init together with a w_cnt==0 beat: msg_init wins, and the beat is ignored without flagging an error.
- Back-to-back blocks: a w_cnt==0 beat in the cycle right after UPDATE is accepted and sees the updated H.
- busy = (state != IDLE).

Decomposition:
- Shared package sha256_pkg holds:
  - K[0:63] constant array
  - IV[0:7] constants
  - state enum (IDLE, ROUND, UPDATE)
  - ROTR and Σ/Ch/Maj functions, also usable by the schedule block's O0/O1
- One combinational sub-module, sha256_round_comb:
  - inputs: a..h, Kt, Wt
  - outputs: a'..h'
  - instantiated once, with the source mux (H or a..h) in front of it.

Test Plan:
- "abc" single block (W0=61626380, W1..W14=0, W15=00000018), 64 consecutive beats -> blk_done pulse 65 cycles after the first beat; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; seq_err=0.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", msg_init once, blocks back-to-back -> two blk_done pulses; final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with random 0-5 cycle gaps between beats -> same digest as the first test; busy stays high across every gap.
- Beat with w_cnt=5 while counter=3 -> seq_err=1 sticky, a..h unchanged; continuing correctly with w_cnt=3 still gives the correct digest; next msg_init clears seq_err.
- reset_n asserted at round 30, then released -> digest=IV, busy=0; a fresh "abc" block gives the correct digest.
- msg_init at round 40 -> block aborted, no blk_done, digest=IV; the following "abc" block gives the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the compression datapath and by the
// message-schedule block.
//   K          : round constants K[0:63]
//   IV         : initial hash value H0..H7
//   state_e    : compression controller states
//   work_t     : eight 32-bit working words, a (H0) in the top bits
//   rotr, big_sigma0/1, small_sigma0/1, ch, maj : the SHA-256 bit functions
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam work_t IV_WORK = '{IV[0], IV[1], IV[2], IV[3],
                                  IV[4], IV[5], IV[6], IV[7]};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    // Schedule-side functions (O0/O1), kept here so both blocks share one source.
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise mod-2^32 sum used for the chaining step H += {a..h}.
    function automatic work_t add_work(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One purely combinational SHA-256 compression round.
//   a..h     : working words entering the round
//   k_t, w_t : round constant and schedule word for this round
//   a_n..h_n : working words leaving the round
module sha256_round_comb
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] k_t,
    input  logic [31:0] w_t,
    output logic [31:0] a_n,
    output logic [31:0] b_n,
    output logic [31:0] c_n,
    output logic [31:0] d_n,
    output logic [31:0] e_n,
    output logic [31:0] f_n,
    output logic [31:0] g_n,
    output logic [31:0] h_n
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1  = h + big_sigma1(e) + ch(e, f, g) + k_t + w_t;
    assign t2  = big_sigma0(a) + maj(a, b, c);

    assign a_n = t1 + t2;
    assign b_n = a;
    assign c_n = b;
    assign d_n = c;
    assign e_n = d + t1;
    assign f_n = e;
    assign g_n = f;
    assign h_n = g;

endmodule

// File: rtl/sha256_main_round.sv
// SHA-256 compression stage: consumes one schedule word per w_vld beat,
// runs 64 rounds on a..h and folds the result into the chained hash.
//   clk, reset_n : clock, asynchronous active-low reset
//   msg_init     : reload IV / abort the current block
//   w_vld, w_cnt, Wt : schedule beat (round index and word)
//   busy         : block in progress (state != IDLE)
//   blk_done     : one-cycle pulse, H0..H7 are updated at the end of it
//   seq_err      : sticky out-of-sequence beat flag
//   digest       : {H0..H7}, H0 in [255:224]
module sha256_main_round
    import sha256_pkg::*;
#(
    parameter int P_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         msg_init,
    input  logic         w_vld,
    input  logic [5:0]   w_cnt,
    input  logic [31:0]  Wt,
    output logic         busy,
    output logic         blk_done,
    output logic         seq_err,
    output logic [255:0] digest
);

    localparam logic [5:0] LAST_CNT = 6'(P_ROUNDS - 1);

    state_e      state;
    state_e      state_nxt;
    work_t       work;
    work_t       hash;
    work_t       src;
    logic [5:0]  cnt;
    logic        accept;
    logic        last;
    logic        bad_beat;
    logic [31:0] a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n;

    // Round 0 starts from the chained hash; later rounds from a..h.
    assign src = (state == IDLE) ? hash : work;

    sha256_round_comb u_round (
        .a   (src.a),
        .b   (src.b),
        .c   (src.c),
        .d   (src.d),
        .e   (src.e),
        .f   (src.f),
        .g   (src.g),
        .h   (src.h),
        .k_t (K[w_cnt]),
        .w_t (Wt),
        .a_n (a_n),
        .b_n (b_n),
        .c_n (c_n),
        .d_n (d_n),
        .e_n (e_n),
        .f_n (f_n),
        .g_n (g_n),
        .h_n (h_n)
    );

    // msg_init overrides any beat in the same cycle, so such a beat is
    // neither accepted nor flagged.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        accept    = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE:    accept = w_vld && !msg_init && (w_cnt == 6'd0);
            ROUND:   accept = w_vld && !msg_init && (w_cnt == cnt);
            default: accept = 1'b0;
        endcase

        if (msg_init) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state_nxt = ROUND;
                ROUND:   if (accept && (w_cnt == LAST_CNT)) state_nxt = UPDATE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign last     = accept && (w_cnt == LAST_CNT);
    assign bad_beat = w_vld && !msg_init && !accept;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            work     <= '0;
            hash     <= IV_WORK;
            cnt      <= '0;
            blk_done <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            blk_done <= last;
            if (msg_init) begin
                work    <= '0;
                cnt     <= '0;
                hash    <= IV_WORK;
                seq_err <= 1'b0;
            end else begin
                if (accept) begin
                    work <= work_t'({a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n});
                    cnt  <= cnt + 6'd1;  // wraps 63 -> 0, ready for the next block
                end
                if (state == UPDATE) begin
                    hash <= add_work(hash, work);
                end
                if (bad_beat) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

    assign busy   = (state != IDLE);
    assign digest = hash;

endmodule

// File: tb/tb_sha256_main_round.sv
// Directed self-checking bench for sha256_main_round. The bench expands the
// 16-word message blocks into W0..W63 itself and compares against known
// SHA-256 digests.
module tb_sha256_main_round;

    localparam logic [255:0] DIG_IV  =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk;
    logic         reset_n;
    logic         msg_init;
    logic         w_vld;
    logic [5:0]   w_cnt;
    logic [31:0]  wt;
    logic         busy;
    logic         blk_done;
    logic         seq_err;
    logic [255:0] digest;

    int tests;
    int fails;
    int cyc;

    logic [31:0] msg   [0:15];
    logic [31:0] sched [0:63];
    logic        early_done;
    logic        busy_drop;

    sha256_main_round dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .msg_init (msg_init),
        .w_vld    (w_vld),
        .w_cnt    (w_cnt),
        .Wt       (wt),
        .busy     (busy),
        .blk_done (blk_done),
        .seq_err  (seq_err),
        .digest   (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic expand();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                sched[t] = msg[t];
            end else begin
                sched[t] = (rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10))
                         + sched[t-7]
                         + (rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                         + sched[t-16];
            end
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        expand();
    endtask

    task automatic load_two(input int blk);
        if (blk == 0) begin
            msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        end else begin
            for (int i = 0; i < 16; i++) msg[i] = 32'h0;
            msg[15] = 32'h000001c0;
        end
        expand();
    endtask

    // Called and returns at posedge+1.
    task automatic init_msg();
        msg_init = 1'b1;
        @(posedge clk); #1;
        msg_init = 1'b0;
    endtask

    // Feeds beats first..last; optional random gaps between beats. Records
    // any blk_done before the final beat and any busy drop inside the block.
    // Returns at posedge+1 of the edge that captured the last beat.
    task automatic feed_beats(input int first, input int last, input int max_gap);
        int gap;
        for (int t = first; t <= last; t++) begin
            w_vld = 1'b1;
            w_cnt = 6'(t);
            wt    = sched[t];
            @(posedge clk); #1;
            w_vld = 1'b0;
            if (t != last) begin
                @(negedge clk);
                if (blk_done) early_done = 1'b1;
                if (!busy)    busy_drop  = 1'b1;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (gap) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (!busy) busy_drop = 1'b1;
                end
            end
        end
    endtask

    // Observes the pulse cycle and the cycle after it.
    task automatic finish_block(output logic done1, output logic done2,
                                output logic busy2, output logic [255:0] dig);
        @(negedge clk);
        done1 = blk_done;
        @(posedge clk); #1;
        @(negedge clk);
        done2 = blk_done;
        busy2 = busy;
        dig   = digest;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (digest !== DIG_IV) begin fails++; $display("FAIL reset_digest got %h need %h", digest, DIG_IV); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b need 0", busy); end
        tests++; if (blk_done !== 1'b0) begin fails++; $display("FAIL reset_blk_done got %b need 0", blk_done); end
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL reset_seq_err got %b need 0", seq_err); end
    endtask

    task automatic test_abc();
        logic d1, d2, b2;
        logic [255:0] dg;
        int c0, n;
        load_abc();
        init_msg();
        early_done = 1'b0;
        busy_drop  = 1'b0;
        c0 = cyc;
        feed_beats(0, 63, 0);
        @(negedge clk);
        n = cyc - c0 + 1;  // first beat's cycle counts as cycle 1
        tests++; if (n !== 65) begin fails++; $display("FAIL abc_done_cycle got %0d need 65", n); end
        tests++; if (blk_done !== 1'b1) begin fails++; $display("FAIL abc_done_pulse got %b need 1", blk_done); end
        tests++; if (early_done !== 1'b0) begin fails++; $display("FAIL abc_early_done got %b need 0", early_done); end
        @(posedge clk); #1;
        @(negedge clk);
        d2 = blk_done; b2 = busy; dg = digest;
        tests++; if (d2 !== 1'b0) begin fails++; $display("FAIL abc_done_width got %b need 0", d2); end
        tests++; if (b2 !== 1'b0) begin fails++; $display("FAIL abc_busy_after got %b need 0", b2); end
        tests++; if (dg !== DIG_ABC) begin fails++; $display("FAIL abc_digest got %h need %h", dg, DIG_ABC); end
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL abc_seq_err got %b need 0", seq_err); end
        d1 = 1'b0;
        tests++; if (busy_drop !== d1) begin fails++; $display("FAIL abc_busy_gap got %b need 0", busy_drop); end
    endtask

    task automatic test_back_to_back();
        logic d1, d2, b2, first_done;
        logic [255:0] dg;
        load_two(0);
        init_msg();
        feed_beats(0, 63, 0);
        @(negedge clk);
        first_done = blk_done;
        @(posedge clk); #1;   // UPDATE done; next beat goes in immediately
        load_two(1);
        feed_beats(0, 63, 0);
        finish_block(d1, d2, b2, dg);
        tests++; if (first_done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b need 1", first_done); end
        tests++; if (d1 !== 1'b1) begin fails++; $display("FAIL b2b_done2 got %b need 1", d1); end
        tests++; if (dg !== DIG_TWO) begin fails++; $display("FAIL b2b_digest got %h need %h", dg, DIG_TWO); end
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL b2b_seq_err got %b need 0", seq_err); end
    endtask

    task automatic test_reset_mid();
        logic d1, d2, b2;
        logic [255:0] dg;
        load_abc();
        feed_beats(0, 29, 0);
        reset_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b need 0", busy); end
        tests++; if (digest !== DIG_IV) begin fails++; $display("FAIL rstmid_digest got %h need %h", digest, DIG_IV); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        feed_beats(0, 63, 0);
        finish_block(d1, d2, b2, dg);
        tests++; if (d1 !== 1'b1) begin fails++; $display("FAIL rstmid_done got %b need 1", d1); end
        tests++; if (dg !== DIG_ABC) begin fails++; $display("FAIL rstmid_abc got %h need %h", dg, DIG_ABC); end
    endtask

    task automatic test_abort();
        logic d1, d2, b2, any_done;
        logic [255:0] dg;
        load_abc();           // chained H holds the previous digest here
        feed_beats(0, 39, 0);
        init_msg();
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (blk_done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b need 0", busy); end
        tests++; if (any_done !== 1'b0) begin fails++; $display("FAIL abort_done got %b need 0", any_done); end
        tests++; if (digest !== DIG_IV) begin fails++; $display("FAIL abort_digest got %h need %h", digest, DIG_IV); end
        feed_beats(0, 63, 0);
        finish_block(d1, d2, b2, dg);
        tests++; if (dg !== DIG_ABC) begin fails++; $display("FAIL abort_abc got %h need %h", dg, DIG_ABC); end
    endtask

    task automatic test_gaps();
        logic d1, d2, b2;
        logic [255:0] dg;
        load_abc();
        init_msg();
        busy_drop = 1'b0;
        feed_beats(0, 63, 5);
        finish_block(d1, d2, b2, dg);
        tests++; if (busy_drop !== 1'b0) begin fails++; $display("FAIL gaps_busy_drop got %b need 0", busy_drop); end
        tests++; if (d1 !== 1'b1) begin fails++; $display("FAIL gaps_done got %b need 1", d1); end
        tests++; if (dg !== DIG_ABC) begin fails++; $display("FAIL gaps_digest got %h need %h", dg, DIG_ABC); end
    endtask

    task automatic test_seq_err();
        logic d1, d2, b2;
        logic [255:0] dg;
        load_abc();
        init_msg();
        // Nonzero index while idle.
        w_vld = 1'b1; w_cnt = 6'd7; wt = 32'hdeadbeef;
        @(posedge clk); #1;
        w_vld = 1'b0;
        @(negedge clk);
        tests++; if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_idle_err got %b need 1", seq_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL seq_idle_busy got %b need 0", busy); end
        init_msg();
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL seq_clear1 got %b need 0", seq_err); end
        // Skip ahead to index 5 while the counter sits at 3.
        feed_beats(0, 2, 0);
        w_vld = 1'b1; w_cnt = 6'd5; wt = sched[5];
        @(posedge clk); #1;
        w_vld = 1'b0;
        @(negedge clk);
        tests++; if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_skip_err got %b need 1", seq_err); end
        feed_beats(3, 63, 0);
        finish_block(d1, d2, b2, dg);
        tests++; if (dg !== DIG_ABC) begin fails++; $display("FAIL seq_digest got %h need %h", dg, DIG_ABC); end
        tests++; if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_sticky got %b need 1", seq_err); end
        init_msg();
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL seq_clear2 got %b need 0", seq_err); end
    endtask

    task automatic test_update_beat();
        load_abc();
        init_msg();
        feed_beats(0, 63, 0);
        // This cycle is UPDATE; a beat here must be rejected.
        w_vld = 1'b1; w_cnt = 6'd0; wt = sched[0];
        @(posedge clk); #1;
        w_vld = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL upd_busy got %b need 0", busy); end
        tests++; if (seq_err !== 1'b1) begin fails++; $display("FAIL upd_seq_err got %b need 1", seq_err); end
        tests++; if (digest !== DIG_ABC) begin fails++; $display("FAIL upd_digest got %h need %h", digest, DIG_ABC); end
    endtask

    task automatic test_init_with_beat();
        msg_init = 1'b1;
        w_vld = 1'b1; w_cnt = 6'd0; wt = 32'h61626380;
        @(posedge clk); #1;
        msg_init = 1'b0;
        w_vld = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL initbeat_busy got %b need 0", busy); end
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL initbeat_seq_err got %b need 0", seq_err); end
        tests++; if (digest !== DIG_IV) begin fails++; $display("FAIL initbeat_digest got %h need %h", digest, DIG_IV); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        msg_init = 1'b0;
        w_vld    = 1'b0;
        w_cnt    = 6'd0;
        wt       = 32'h0;
        early_done = 1'b0;
        busy_drop  = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        test_abc();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        test_gaps();
        test_seq_err();
        test_update_beat();
        test_init_with_beat();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
